// File: rtl/jk_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : jk_mod_counter
// Description : Modulo-N up/down counter that drives its state through JK
//               excitation and exports J/K so an external JK bank can track it.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_mod_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             Clk_In,
   input  logic             Reset_In,
   input  logic             Enable_In,
   input  logic             Up_In,
   input  logic             Load_In,
   input  logic [WIDTH-1:0] Load_Value_In,
   output logic [WIDTH-1:0] Count_Out,
   output logic [WIDTH-1:0] J_Out,
   output logic [WIDTH-1:0] K_Out,
   output logic             Terminal_Out,
   output logic             Wrap_Out,
   output logic             Load_Err_Out
);

   // One extra bit so MODULUS = 2^WIDTH is representable without overflow.
   localparam logic [WIDTH:0] c_MODULUS = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] c_MAX     = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             r_load_err;

   logic [WIDTH:0]   w_count_ext;
   logic [WIDTH:0]   w_load_ext;
   logic [WIDTH:0]   w_next_ext;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH-1:0] w_q_next;
   logic             w_terminal;
   logic             w_load_bad;

   assign w_count_ext = {1'b0, r_count};
   assign w_load_ext  = {1'b0, Load_Value_In};
   assign w_load_bad  = (w_load_ext >= c_MODULUS);
   assign w_terminal  = Up_In ? (w_count_ext == c_MAX) : (w_count_ext == '0);

   always_comb begin
      w_next_ext = w_count_ext;
      if (Reset_In) begin
         w_next_ext = '0;
      end else if (Load_In) begin
         w_next_ext = w_load_bad ? '0 : w_load_ext;
      end else if (Enable_In) begin
         if (Up_In) begin
            w_next_ext = (w_count_ext == c_MAX) ? '0 : w_count_ext + 1'b1;
         end else begin
            w_next_ext = (w_count_ext == '0) ? c_MAX : w_count_ext - 1'b1;
         end
      end
   end

   assign w_next = w_next_ext[WIDTH-1:0];

   // Excitation and JK-semantics update, one flip-flop per bit.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign w_j[gi]      = w_next[gi] & ~r_count[gi];
         assign w_k[gi]      = ~w_next[gi] & r_count[gi];
         assign w_q_next[gi] = (w_j[gi] & ~r_count[gi]) | (~w_k[gi] & r_count[gi]);
      end
   endgenerate

   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         r_count    <= '0;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_count    <= w_q_next;
         r_wrap     <= Enable_In & ~Load_In & w_terminal;
         r_load_err <= Load_In & w_load_bad;
      end
   end

   always_ff @(posedge Clk_In) begin
      if (!Reset_In) begin
         a_jk_matches_next : assert (w_q_next == w_next);
         a_jk_never_both   : assert ((w_j & w_k) == '0);
         a_next_in_range   : assert (w_next_ext < c_MODULUS);
      end
   end

   assign Count_Out    = r_count;
   assign J_Out        = w_j;
   assign K_Out        = w_k;
   assign Terminal_Out = w_terminal;
   assign Wrap_Out     = r_wrap;
   assign Load_Err_Out = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for jk_mod_counter: a MODULUS=10 and a MODULUS=16 instance share
// stimulus and are checked against an arithmetic modulo reference model.
module tb_jk_mod_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       up  = 1'b1;
   logic       ld  = 1'b0;
   logic [3:0] lv  = 4'd0;

   logic [3:0] cnt_o  [2];
   logic [3:0] j_o    [2];
   logic [3:0] k_o    [2];
   logic       term_o [2];
   logic       wrap_o [2];
   logic       err_o  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
      .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Up_In(up), .Load_In(ld),
      .Load_Value_In(lv), .Count_Out(cnt_o[0]), .J_Out(j_o[0]), .K_Out(k_o[0]),
      .Terminal_Out(term_o[0]), .Wrap_Out(wrap_o[0]), .Load_Err_Out(err_o[0]));

   jk_mod_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
      .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Up_In(up), .Load_In(ld),
      .Load_Value_In(lv), .Count_Out(cnt_o[1]), .J_Out(j_o[1]), .K_Out(k_o[1]),
      .Terminal_Out(term_o[1]), .Wrap_Out(wrap_o[1]), .Load_Err_Out(err_o[1]));

   // Reference model: plain modulo arithmetic on integers.
   int         m_cnt  [2] = '{0, 0};
   bit         m_wrap [2] = '{0, 0};
   bit         m_err  [2] = '{0, 0};
   logic [3:0] shadow [2] = '{4'd0, 4'd0};

   function automatic int mod_of(int d);
      return (d == 0) ? 10 : 16;
   endfunction

   function automatic int model_next(int c, int m);
      if (rst) return 0;
      if (ld) return (int'(lv) < m) ? int'(lv) : 0;
      if (en) return up ? (c + 1) % m : (c + m - 1) % m;
      return c;
   endfunction

   function automatic bit model_term(int c, int m);
      return up ? (c == m - 1) : (c == 0);
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         m_wrap[d] <= en && !ld && !rst && model_term(m_cnt[d], mod_of(d));
         m_err[d]  <= !rst && ld && (int'(lv) >= mod_of(d));
         m_cnt[d]  <= model_next(m_cnt[d], mod_of(d));
         shadow[d] <= (j_o[d] & ~shadow[d]) | (~k_o[d] & shadow[d]);
      end
   end

   task automatic test_reset();
      rst = 1'b1; ld = 1'b1; en = 1'b1; up = 1'b1; lv = 4'd3;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         checks += 3;
         if (cnt_o[d] !== 4'd0) begin errors++; $display("FAIL reset_count dut%0d: got %0d expected 0", d, cnt_o[d]); end
         if (wrap_o[d] !== 1'b0) begin errors++; $display("FAIL reset_wrap dut%0d: got %b expected 0", d, wrap_o[d]); end
         if (err_o[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b expected 0", d, err_o[d]); end
      end
      rst = 1'b0; ld = 1'b0; en = 1'b0;
   endtask

   task automatic test_count_up();
      rst = 1'b0; ld = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (m_cnt[0] == 9) begin
            checks++;
            if (j_o[0] !== 4'b0000 || k_o[0] !== 4'b1001) begin
               errors++;
               $display("FAIL up_9to0_jk: got J=%b K=%b expected J=0000 K=1001", j_o[0], k_o[0]);
            end
         end
         @(posedge clk); #1;
         checks += 2;
         if (cnt_o[0] !== 4'((i + 1) % 10)) begin
            errors++; $display("FAIL up_count step%0d: got %0d expected %0d", i, cnt_o[0], (i + 1) % 10);
         end
         if (wrap_o[0] !== (i == 9)) begin
            errors++; $display("FAIL up_wrap step%0d: got %b expected %b", i, wrap_o[0], i == 9);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_count_down();
      logic [3:0] exp_seq [7];
      exp_seq = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
      ld = 1'b1; lv = 4'd5; en = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (cnt_o[0] !== 4'd5) begin errors++; $display("FAIL down_load5: got %0d expected 5", cnt_o[0]); end
      ld = 1'b0; en = 1'b1; up = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #1;
         checks++;
         if (term_o[0] !== (cnt_o[0] == 4'd0 && m_cnt[0] == 0)) begin
            errors++; $display("FAIL down_terminal step%0d: got %b at count %0d", i, term_o[0], cnt_o[0]);
         end
         @(posedge clk); #1;
         checks += 2;
         if (cnt_o[0] !== exp_seq[i]) begin
            errors++; $display("FAIL down_count step%0d: got %0d expected %0d", i, cnt_o[0], exp_seq[i]);
         end
         if (wrap_o[0] !== (exp_seq[i] == 4'd9)) begin
            errors++; $display("FAIL down_wrap step%0d: got %b expected %b", i, wrap_o[0], exp_seq[i] == 4'd9);
         end
      end
      en = 1'b0; up = 1'b1;
   endtask

   task automatic test_load_err();
      ld = 1'b1; lv = 4'd12; en = 1'b0;
      @(posedge clk); #1;
      checks += 2;
      if (cnt_o[0] !== 4'd0) begin errors++; $display("FAIL bad_load_count: got %0d expected 0", cnt_o[0]); end
      if (err_o[0] !== 1'b1) begin errors++; $display("FAIL bad_load_err: got %b expected 1", err_o[0]); end
      ld = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (err_o[0] !== 1'b0) begin errors++; $display("FAIL bad_load_err_pulse: got %b expected 0", err_o[0]); end
      ld = 1'b1; lv = 4'd7; en = 1'b1; up = 1'b1;
      @(posedge clk); #1;
      checks += 3;
      if (cnt_o[0] !== 4'd7) begin errors++; $display("FAIL load_beats_enable: got %0d expected 7", cnt_o[0]); end
      if (wrap_o[0] !== 1'b0) begin errors++; $display("FAIL load_no_wrap: got %b expected 0", wrap_o[0]); end
      if (err_o[0] !== 1'b0) begin errors++; $display("FAIL good_load_err: got %b expected 0", err_o[0]); end
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         lv = 4'(13 + i);
         @(posedge clk); #1;
         checks++;
         if (err_o[0] !== 1'b1) begin errors++; $display("FAIL back_to_back_err load%0d: got %b expected 1", i, err_o[0]); end
      end
      ld = 1'b0;
   endtask

   task automatic test_reset_override();
      ld = 1'b1; lv = 4'd6; en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; ld = 1'b1; lv = 4'd3; en = 1'b1; up = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (j_o[d] !== 4'b0000 || k_o[d] !== 4'b0110) begin
            errors++; $display("FAIL reset_jk dut%0d: got J=%b K=%b expected J=0000 K=0110", d, j_o[d], k_o[d]);
         end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         checks += 2;
         if (cnt_o[d] !== 4'd0) begin errors++; $display("FAIL reset_override_count dut%0d: got %0d expected 0", d, cnt_o[d]); end
         if (wrap_o[d] !== 1'b0) begin errors++; $display("FAIL reset_override_wrap dut%0d: got %b expected 0", d, wrap_o[d]); end
      end
      rst = 1'b0; ld = 1'b0; en = 1'b0;
   endtask

   task automatic test_full_range();
      ld = 1'b1; lv = 4'd15; en = 1'b0;
      @(posedge clk); #1;
      ld = 1'b0; en = 1'b1; up = 1'b1;
      #1;
      checks++;
      if (term_o[1] !== 1'b1) begin errors++; $display("FAIL mod16_terminal: got %b expected 1", term_o[1]); end
      @(posedge clk); #1;
      checks += 2;
      if (cnt_o[1] !== 4'd0) begin errors++; $display("FAIL mod16_wrap_count: got %0d expected 0", cnt_o[1]); end
      if (wrap_o[1] !== 1'b1) begin errors++; $display("FAIL mod16_wrap_flag: got %b expected 1", wrap_o[1]); end
      en = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         rst = ($urandom % 32) == 0;
         ld  = ($urandom % 8) == 0;
         en  = ($urandom % 4) != 0;
         up  = $urandom % 2;
         lv  = 4'($urandom % 16);
         #1;
         for (int d = 0; d < 2; d++) begin
            logic [3:0] cur, nxt;
            cur = 4'(m_cnt[d]);
            nxt = 4'(model_next(m_cnt[d], mod_of(d)));
            checks += 4;
            if (j_o[d] !== (nxt & ~cur)) begin errors++; $display("FAIL rand_j dut%0d cyc%0d: got %b expected %b", d, i, j_o[d], nxt & ~cur); end
            if (k_o[d] !== (~nxt & cur)) begin errors++; $display("FAIL rand_k dut%0d cyc%0d: got %b expected %b", d, i, k_o[d], ~nxt & cur); end
            if ((j_o[d] & k_o[d]) !== 4'b0000) begin errors++; $display("FAIL rand_jk_both dut%0d cyc%0d: got %b expected 0000", d, i, j_o[d] & k_o[d]); end
            if (term_o[d] !== model_term(m_cnt[d], mod_of(d))) begin
               errors++; $display("FAIL rand_terminal dut%0d cyc%0d: got %b expected %b", d, i, term_o[d], model_term(m_cnt[d], mod_of(d)));
            end
         end
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            checks += 4;
            if (cnt_o[d] !== 4'(m_cnt[d])) begin errors++; $display("FAIL rand_count dut%0d cyc%0d: got %0d expected %0d", d, i, cnt_o[d], m_cnt[d]); end
            if (wrap_o[d] !== m_wrap[d]) begin errors++; $display("FAIL rand_wrap dut%0d cyc%0d: got %b expected %b", d, i, wrap_o[d], m_wrap[d]); end
            if (err_o[d] !== m_err[d]) begin errors++; $display("FAIL rand_err dut%0d cyc%0d: got %b expected %b", d, i, err_o[d], m_err[d]); end
            if (shadow[d] !== 4'(m_cnt[d])) begin errors++; $display("FAIL rand_shadow dut%0d cyc%0d: got %0d expected %0d", d, i, shadow[d], m_cnt[d]); end
         end
      end
      rst = 1'b0; ld = 1'b0; en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_load_err();
      test_reset_override();
      test_full_range();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
